// File: rtl/compare_pipe.sv
// compare_pipe: two-stage valid/ready compare pipeline with a sideband tag.
// Define COMPARE_PIPE_UNSIGNED_EN to enable the unsigned ops (110, 111); otherwise they report illegal_op.
module compare_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [2:0]       func_choice,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             comp_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_op
);

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b010,
        OP_GT  = 3'b011,
        OP_LE  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_lt_q, s1_lt_d;
    logic             s1_eq_q, s1_eq_d;
    op_e              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_result_q, s2_result_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s1_load, s2_load;
    logic [WIDTH:0]   a_ext, b_ext, diff;

    // One extra bit keeps A-B exact, so its top bit is the less-than flag for either signedness.
`ifdef COMPARE_PIPE_UNSIGNED_EN
    assign a_ext = (func_choice[2:1] == 2'b11) ? {1'b0, busA} : {busA[WIDTH-1], busA};
    assign b_ext = (func_choice[2:1] == 2'b11) ? {1'b0, busB} : {busB[WIDTH-1], busB};
`else
    assign a_ext = {busA[WIDTH-1], busA};
    assign b_ext = {busB[WIDTH-1], busB};
`endif
    assign diff = a_ext - b_ext;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lt_d    = s1_lt_q;
        s1_eq_d    = s1_eq_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lt_d  = diff[WIDTH];
                s1_eq_d  = (diff == '0);
                s1_op_d  = op_e'(func_choice);
                s1_tag_d = in_tag;
            end
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_illegal_d = s2_illegal_q;
        s2_tag_d     = s2_tag_q;
        if (s2_load) begin
            s2_valid_d   = s1_valid_q;
            s2_result_d  = 1'b0;
            s2_illegal_d = 1'b0;
            if (s1_valid_q) begin
                s2_tag_d = s1_tag_q;
                case (s1_op_q)
                    OP_EQ:  s2_result_d = s1_eq_q;
                    OP_NE:  s2_result_d = !s1_eq_q;
                    OP_LT:  s2_result_d = s1_lt_q;
                    OP_GT:  s2_result_d = !s1_lt_q && !s1_eq_q;
                    OP_LE:  s2_result_d = s1_lt_q || s1_eq_q;
                    OP_GE:  s2_result_d = !s1_lt_q;
`ifdef COMPARE_PIPE_UNSIGNED_EN
                    OP_LTU: s2_result_d = s1_lt_q;
                    OP_GEU: s2_result_d = !s1_lt_q;
`else
                    OP_LTU: s2_illegal_d = 1'b1;
                    OP_GEU: s2_illegal_d = 1'b1;
`endif
                    default: s2_illegal_d = 1'b1;
                endcase
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_lt_q      <= 1'b0;
            s1_eq_q      <= 1'b0;
            s1_op_q      <= OP_EQ;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 1'b0;
            s2_illegal_q <= 1'b0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_lt_q      <= s1_lt_d;
            s1_eq_q      <= s1_eq_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_illegal_q <= s2_illegal_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign comp_result = s2_result_q;
    assign illegal_op  = s2_illegal_q;
    assign out_tag     = s2_tag_q;

endmodule

// File: tb/tb_compare_pipe.sv
// Scoreboard bench for compare_pipe (WIDTH=32): the driver pushes model results on accept, the monitor pops on output transfer.
// Honours COMPARE_PIPE_UNSIGNED_EN the same way as the design build.
module tb_compare_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
`ifdef COMPARE_PIPE_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] busA, busB;
    logic [2:0]       func_choice;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic             comp_result, illegal_op;
    logic [TAG_W-1:0] out_tag;

    compare_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .busA(busA), .busB(busB), .func_choice(func_choice), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .comp_result(comp_result), .out_tag(out_tag), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             res;
        logic             ill;
        int               exp_cyc;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               pops = 0;
    logic             mon_en = 1'b0;
    logic             strict_lat = 1'b0;
    logic [TAG_W-1:0] next_tag = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain SystemVerilog relational operators on the raw operands.
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.tag = '0;
        e.exp_cyc = 0;
        e.ill = 1'b0;
        case (op)
            3'd0: e.res = (a == b);
            3'd1: e.res = (a != b);
            3'd2: e.res = ($signed(a) <  $signed(b));
            3'd3: e.res = ($signed(a) >  $signed(b));
            3'd4: e.res = ($signed(a) <= $signed(b));
            3'd5: e.res = ($signed(a) >= $signed(b));
            3'd6: e.res = (a <  b);
            default: e.res = (a >= b);
        endcase
        if (op[2:1] == 2'b11 && !UNS_EN) begin
            e.res = 1'b0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ordy, output logic fired);
        exp_t e;
        @(negedge clk);
        in_valid    = v;
        func_choice = op;
        busA        = a;
        busB        = b;
        in_tag      = next_tag;
        out_ready   = ordy;
        #1;
        fired = v && in_ready && !rst;
        if (fired) begin
            e = model(op, a, b);
            e.tag = next_tag;
            e.exp_cyc = cyc + 2;
            sb_q.push_back(e);
            next_tag = next_tag + 1'b1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic fired;
        int   tries;
        fired = 1'b0;
        tries = 0;
        while (!fired && tries < 20) begin
            drive(1'b1, op, a, b, 1'b1, fired);
            tries++;
        end
        if (!fired) check("send_accept_timeout", 64'(tries), 64'(0));
    endtask

    task automatic drain();
        logic fired;
        for (int i = 0; i < 60 && sb_q.size() != 0; i++)
            drive(1'b0, 3'd0, '0, '0, 1'b1, fired);
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    // Monitor: samples 2 time units after the falling edge, ahead of the next rising edge.
    initial begin
        logic             hold_pend;
        logic             h_res, h_ill;
        logic [TAG_W-1:0] h_tag;
        exp_t             e;
        hold_pend = 1'b0;
        h_res = 1'b0;
        h_ill = 1'b0;
        h_tag = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                if (hold_pend) begin
                    check("hold_valid",   64'(out_valid),   64'(1));
                    check("hold_result",  64'(comp_result), 64'(h_res));
                    check("hold_illegal", 64'(illegal_op),  64'(h_ill));
                    check("hold_tag",     64'(out_tag),     64'(h_tag));
                end
                if (out_valid) begin
                    if (out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_output_tag", 64'(out_tag), 64'hDEAD);
                        end else begin
                            e = sb_q.pop_front();
                            pops++;
                            check("out_tag",     64'(out_tag),     64'(e.tag));
                            check("comp_result", 64'(comp_result), 64'(e.res));
                            check("illegal_op",  64'(illegal_op),  64'(e.ill));
                            if (strict_lat) check("latency_exact", 64'(cyc), 64'(e.exp_cyc));
                            else            check("latency_min", 64'(cyc >= e.exp_cyc), 64'(1));
                        end
                    end
                    hold_pend = !out_ready;
                    h_res = comp_result;
                    h_ill = illegal_op;
                    h_tag = out_tag;
                end else begin
                    hold_pend = 1'b0;
                    check("idle_result",  64'(comp_result), 64'(0));
                    check("idle_illegal", 64'(illegal_op),  64'(0));
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             fired;
        logic             seen_not_ready;
        int               issued;
        int               pops0;
        logic [2:0]       op;
        logic [WIDTH-1:0] a, b;

        rst = 1'b1;
        in_valid = 1'b0;
        busA = '0;
        busB = '0;
        func_choice = 3'd0;
        in_tag = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready",    64'(in_ready),    64'(1));
        check("rst_out_valid",   64'(out_valid),   64'(0));
        check("rst_comp_result", 64'(comp_result), 64'(0));
        check("rst_illegal_op",  64'(illegal_op),  64'(0));
        check("rst_out_tag",     64'(out_tag),     64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        mon_en = 1'b1;

        // Directed corner vectors, back-to-back with out_ready held high.
        strict_lat = 1'b1;
        send(3'b010, 32'h8000_0000, 32'h7FFF_FFFF);
        send(3'b011, 32'h8000_0000, 32'h7FFF_FFFF);
        send(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(3'b101, 32'h0000_0005, 32'hFFFF_FFFB);
        send(3'b110, 32'h0000_0001, 32'hFFFF_FFFF);
        send(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
        send(3'b011, 32'h7FFF_FFFF, 32'h8000_0000);
        send(3'b100, 32'h0000_0000, 32'hFFFF_FFFF);
        drain();

        // Tags 0..9 streamed, consumer stalls for cycles 3-6.
        strict_lat = 1'b0;
        next_tag = '0;
        seen_not_ready = 1'b0;
        issued = 0;
        pops0 = pops;
        for (int c = 0; c < 30; c++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            drive(issued < 10, op, a, b, !(c >= 3 && c <= 6), fired);
            if (issued < 10 && !in_ready) seen_not_ready = 1'b1;
            if (fired) issued++;
        end
        drain();
        check("stream_issued", 64'(issued), 64'(10));
        check("stream_in_ready_dropped", 64'(seen_not_ready), 64'(1));
        check("stream_returned", 64'(pops - pops0), 64'(10));

        // Random traffic with random back-pressure; equal and extreme operands are favoured.
        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                2: b = 32'h8000_0000;
                3: b = 32'h7FFF_FFFF;
                default: b = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, op, a, b, $urandom_range(0, 3) != 0, fired);
        end
        drain();

        // Reset with two requests in flight.
        drive(1'b1, 3'b000, 32'd7, 32'd7, 1'b0, fired);
        drive(1'b1, 3'b001, 32'd7, 32'd8, 1'b0, fired);
        drive(1'b0, 3'b000, '0, '0, 1'b0, fired);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid",   64'(out_valid),   64'(0));
        check("midrst_comp_result", 64'(comp_result), 64'(0));
        check("midrst_illegal_op",  64'(illegal_op),  64'(0));
        check("midrst_out_tag",     64'(out_tag),     64'(0));
        check("midrst_in_ready",    64'(in_ready),    64'(1));
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b0;
        strict_lat = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, '0, '0, 1'b1, fired);
        pops0 = pops;
        send(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        drain();
        check("post_rst_returned", 64'(pops - pops0), 64'(1));

        check("final_queue_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compare_pipe.md
COMPARE_PIPE -- requirements
Module: compare_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each compare.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 in_valid  input  1  request present on busA/busB/func_choice/in_tag.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 busA  input  WIDTH  first operand.
REQ-008 busB  input  WIDTH  second operand.
REQ-009 func_choice  input  3  compare operation select.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result present on comp_result/out_tag/illegal_op.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 comp_result  output  1  1 = condition true, 0 = false.
REQ-014 out_tag  output  TAG_W  tag of the request that produced this result.
REQ-015 illegal_op  output  1  1 = func_choice not supported in this build.

Function
REQ-016 Ops: 000 A==B; 001 A!=B; 010 A<B signed; 011 A>B signed; 100 A<=B signed; 101 A>=B signed; 110 A<B unsigned; 111 A>=B unsigned.
REQ-017 Signed ops SHALL be full two's-complement compares of both operands over all WIDTH bits (not sign-of-A tests).
REQ-018 Transfer in: in_valid & in_ready on a rising edge; transfer out: out_valid & out_ready.
REQ-019 Two register stages: S1 captures operands, op, tag, and computes A-B (WIDTH+1 bits, sign-extended or zero-extended per op) and the equality flag; S2 holds the final result.
REQ-020 Latency SHALL be exactly 2 cycles from in-transfer edge to out_valid=1 when out_ready is held 1.
REQ-021 Throughput SHALL be 1 compare per cycle when out_ready=1.
REQ-022 S2 loads from S1 when !S2.valid | out_ready; S1 loads when !S1.valid | S1 advances.
REQ-023 in_ready SHALL equal !S1.valid | !S2.valid | out_ready (combinational, no dependence on in_valid).
REQ-024 While out_valid=1 and out_ready=0, comp_result, out_tag, illegal_op SHALL hold stable.
REQ-025 Simultaneous in-transfer and out-transfer with both stages full SHALL lose no request and reorder nothing; results return in request order.
REQ-026 When out_valid=0, comp_result and illegal_op SHALL be 0; out_tag holds last value.
REQ-027 Illegal op SHALL produce comp_result=0, illegal_op=1, and still occupy one pipeline slot.

Reset
REQ-028 rst=1 SHALL immediately clear S1.valid, S2.valid, out_valid, comp_result, illegal_op, out_tag to 0, independent of clk.
REQ-029 Requests in flight at reset assertion SHALL be discarded without output.
REQ-030 in_ready SHALL be 1 during and after reset.

Configuration
REQ-031 Macro COMPARE_PIPE_UNSIGNED_EN defined: ops 110 and 111 function per REQ-016, illegal_op never asserts.
REQ-032 Macro COMPARE_PIPE_UNSIGNED_EN undefined: ops 110 and 111 are illegal per REQ-027; ops 000-101 unchanged; unsigned extend path not built.

Verification
REQ-033 WIDTH=32, op 010, A=0x80000000, B=0x7FFFFFFF -> result 1 two cycles later; op 011 same operands -> 0.
REQ-034 op 100, A=B=0xFFFFFFFF -> 1; op 000 -> 1; op 001 -> 0; op 101 A=0x00000005,B=0xFFFFFFFB -> 1.
REQ-035 Macro defined, op 110, A=0x00000001, B=0xFFFFFFFF -> result 1, illegal_op 0; macro undefined same stimulus -> result 0, illegal_op 1.
REQ-036 Stream tags 0..9 back-to-back, out_ready low for cycles 3-6 -> in_ready drops after both stages fill, outputs held, all 10 tags return in order, none duplicated.
REQ-037 Assert rst mid-stream with 2 in flight -> out_valid 0 at once, no stale result after release; next request gives result 2 cycles after accept.
REQ-038 WIDTH=8 build: op 010, A=0x80, B=0x01 -> 1; op 110 (macro on) same operands -> 0.
